// File: rtl/phasecalc_if.sv
// phasecalc_if: start/busy handshake and data bundle for the phase calculator.
//   start : request, sampled on the rising clock edge while idle
//   busy  : conversion in progress
//   x, y  : signed real/imaginary input sample
//   angle : signed phase in degrees, Q(OUTPUTBITSIZE-FRACBITS).FRACBITS
// master = requester (drives start/x/y), slave = phasecalc.
interface phasecalc_if #(
  parameter int INPUTBITSIZE  = 13,
  parameter int OUTPUTBITSIZE = 19
);
  logic                            start;
  logic                            busy;
  logic signed [INPUTBITSIZE-1:0]  x;
  logic signed [INPUTBITSIZE-1:0]  y;
  logic signed [OUTPUTBITSIZE-1:0] angle;

  modport master (output start, x, y, input  busy, angle);
  modport slave  (input  start, x, y, output busy, angle);
endinterface

// File: rtl/phasecalc.sv
// phasecalc: sequential vectoring-mode CORDIC, angle = atan2(y, x) in degrees.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : phasecalc_if slave (start/busy handshake, x/y in, angle out)
// IDLE -> PRE (quadrant fold) -> ITER (NITER micro-rotations) -> DONE.
// busy is high for NITER+2 cycles; angle updates when busy falls.
module phasecalc #(
  parameter int INPUTBITSIZE  = 13,
  parameter int OUTPUTBITSIZE = 19,
  parameter int FRACBITS      = 10,
  parameter int NITER         = 16,
  parameter int ZFRAC         = 16
) (
  input  logic        clock,
  input  logic        reset,
  phasecalc_if.slave  bus
);
  // 3 guard bits cover CORDIC gain and negating the most negative input.
  // GFRAC bits below the input LSB keep y>>>i / x>>>i from collapsing to
  // zero in the late iterations, which otherwise biases z by the tail of
  // the atan series.
  localparam int GFRAC = 6;
  localparam int W     = INPUTBITSIZE + 3 + GFRAC;
  localparam int ZW    = ZFRAC + 10;             // sign + 9 integer bits (+-180)
  localparam int SH    = ZFRAC - FRACBITS;
  localparam int IW    = (NITER > 1) ? $clog2(NITER) : 1;

  localparam logic signed [ZW-1:0] Z90  = ZW'(90 * (1 << ZFRAC));
  localparam logic signed [ZW-1:0] ZRND = ZW'(1 << (SH - 1));

  typedef enum logic [1:0] {IDLE, PRE, ITER, DONE} state_t;

  // atan(2^-i) in degrees, 16 fractional bits.
  function automatic logic signed [ZW-1:0] atan_tab(input logic [IW-1:0] i);
    case (int'(i))
      0:  atan_tab = ZW'(2949120);
      1:  atan_tab = ZW'(1740967);
      2:  atan_tab = ZW'(919879);
      3:  atan_tab = ZW'(466945);
      4:  atan_tab = ZW'(234379);
      5:  atan_tab = ZW'(117304);
      6:  atan_tab = ZW'(58666);
      7:  atan_tab = ZW'(29335);
      8:  atan_tab = ZW'(14668);
      9:  atan_tab = ZW'(7334);
      10: atan_tab = ZW'(3667);
      11: atan_tab = ZW'(1833);
      12: atan_tab = ZW'(917);
      13: atan_tab = ZW'(458);
      14: atan_tab = ZW'(229);
      15: atan_tab = ZW'(115);
      default: atan_tab = '0;
    endcase
  endfunction

  state_t                     state_q, state_d;
  logic signed [W-1:0]        x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0]       z_q, z_d;
  logic [IW-1:0]              it_q, it_d;
  logic                       zero_q, zero_d;
  logic signed [OUTPUTBITSIZE-1:0] angle_q, angle_d;

  logic signed [W-1:0]        xs, ys;
  logic signed [ZW-1:0]       zr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      it_q    <= '0;
      zero_q  <= 1'b0;
      angle_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      it_q    <= it_d;
      zero_q  <= zero_d;
      angle_q <= angle_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    it_d    = it_q;
    zero_d  = zero_q;
    angle_d = angle_q;
    xs      = x_q >>> it_q;
    ys      = y_q >>> it_q;
    zr      = z_q + ZRND;
    case (state_q)
      IDLE: if (bus.start) begin
        x_d     = {{3{bus.x[INPUTBITSIZE-1]}}, bus.x, {GFRAC{1'b0}}};
        y_d     = {{3{bus.y[INPUTBITSIZE-1]}}, bus.y, {GFRAC{1'b0}}};
        // (0,0) would otherwise accumulate the whole atan series.
        zero_d  = (bus.x == '0) && (bus.y == '0);
        state_d = PRE;
      end
      PRE: begin
        // Fold left half-plane into the right so the iterations converge.
        if (!x_q[W-1]) begin
          z_d = '0;
        end else if (!y_q[W-1]) begin
          x_d = y_q;
          y_d = -x_q;
          z_d = Z90;
        end else begin
          x_d = -y_q;
          y_d = x_q;
          z_d = -Z90;
        end
        it_d    = '0;
        state_d = ITER;
      end
      ITER: begin
        if (!y_q[W-1]) begin
          x_d = x_q + ys;
          y_d = y_q - xs;
          z_d = z_q + atan_tab(it_q);
        end else begin
          x_d = x_q - ys;
          y_d = y_q + xs;
          z_d = z_q - atan_tab(it_q);
        end
        it_d = it_q + 1'b1;
        if (it_q == IW'(NITER - 1)) state_d = DONE;
      end
      DONE: begin
        angle_d = zero_q ? '0 : OUTPUTBITSIZE'(zr >>> SH);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.angle = angle_q;
endmodule

// File: tb/tb_phasecalc.sv
// tb_phasecalc: directed + randomized checks of phasecalc against a
// floating-point atan2 reference.
module tb_phasecalc;
  localparam int IB = 13;
  localparam int OB = 19;
  localparam int NSWEEP = 3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  phasecalc_if #(.INPUTBITSIZE(IB), .OUTPUTBITSIZE(OB)) bus ();

  phasecalc #(
    .INPUTBITSIZE(IB), .OUTPUTBITSIZE(OB), .FRACBITS(10), .NITER(16), .ZFRAC(16)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  function automatic int ref_angle(input int xv, input int yv);
    real a;
    if (xv == 0 && yv == 0) return 0;
    a = $atan2(real'(yv), real'(xv)) * 180.0 / 3.14159265358979323846;
    return int'($floor(a * 1024.0 + 0.5));
  endfunction

  task automatic check_eq(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int xv, input int yv,
                            input int obs, input int tol);
    int  exp;
    logic ok;
    exp = ref_angle(xv, yv);
    ok  = ((obs - exp) <= tol) && ((exp - obs) <= tol);
    total++;
    assert (ok === 1'b1) else begin
      bad++;
      $error("FAIL %s (x=%0d y=%0d): got %0d expected %0d +-%0d", tag, xv, yv, obs, exp, tol);
    end
  endtask

  // Issue one conversion; report the angle and how many sampled cycles busy stayed high.
  task automatic run_conv(input int xv, input int yv, output int ang, output int cyc);
    bus.x = IB'(xv);
    bus.y = IB'(yv);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(posedge clk); #1;
    end
    ang = int'(bus.angle);
  endtask

  typedef struct { int x; int y; string tag; } vec_t;

  initial begin
    int   ang, cyc, xv, yv, amp;
    real  th;
    vec_t dirs[$];

    bus.start = 1'b0;
    bus.x = '0;
    bus.y = '0;

    // Reset held while start is asserted: nothing may happen.
    #2;
    bus.start = 1'b1;
    bus.x = IB'(1000);
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", int'(bus.busy), 0);
    check_eq("reset_angle", int'(bus.angle), 0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_conv(1000, 0, ang, cyc);
    check_eq("busy_len", cyc, 18);
    check_near("x_axis", 1000, 0, ang, 16);

    dirs.push_back('{0, 1000, "pos_y"});
    dirs.push_back('{-1000, 0, "neg_x_180"});
    dirs.push_back('{0, -1000, "neg_y"});
    dirs.push_back('{1000, -1000, "diag_q4"});
    dirs.push_back('{-4096, -4096, "min_min"});
    dirs.push_back('{4095, 4095, "max_max"});
    dirs.push_back('{-4096, 4095, "min_max"});
    dirs.push_back('{-4096, -1, "near_neg180"});
    dirs.push_back('{0, 0, "origin"});
    foreach (dirs[i]) begin
      run_conv(dirs[i].x, dirs[i].y, ang, cyc);
      check_near(dirs[i].tag, dirs[i].x, dirs[i].y, ang, 16);
    end
    check_eq("neg_x_exact", ref_angle(-1000, 0), 184320);

    // start pulsed mid-conversion with different operands is ignored.
    bus.x = IB'(3000);
    bus.y = IB'(500);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    repeat (3) begin @(posedge clk); #1; cyc++; end
    bus.x = IB'(-2000);
    bus.y = IB'(-100);
    bus.start = 1'b1;
    @(posedge clk); #1;
    cyc++;
    bus.start = 1'b0;
    while (bus.busy === 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("ignore_busy_len", cyc, 19);  // 18 busy samples + the idle one
    check_near("ignore_start", 3000, 500, int'(bus.angle), 16);

    // Back-to-back conversions.
    run_conv(-1500, 2500, ang, cyc);
    check_near("b2b_first", -1500, 2500, ang, 16);
    run_conv(2200, -3100, ang, cyc);
    check_near("b2b_second", 2200, -3100, ang, 16);

    // Reset during iteration 5 aborts and clears.
    bus.x = IB'(1000);
    bus.y = IB'(1000);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", int'(bus.busy), 0);
    check_eq("abort_angle", int'(bus.angle), 0);
    @(posedge clk); #1;
    check_eq("abort_hold_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_conv(-700, -2900, ang, cyc);
    check_eq("after_abort_len", cyc, 18);
    check_near("after_abort", -700, -2900, ang, 16);

    // Randomized sweep: a rotating complex signal, plus some full-range raw pairs.
    for (int n = 0; n < NSWEEP; n++) begin
      if (n % 4 == 3) begin
        xv = int'($urandom_range(8191)) - 4096;
        yv = int'($urandom_range(8191)) - 4096;
        run_conv(xv, yv, ang, cyc);
        check_near("sweep_raw", xv, yv, ang, 1024);
      end else begin
        th  = real'($urandom_range(359999)) / 1000.0 * 3.14159265358979323846 / 180.0;
        amp = int'($urandom_range(4000, 2000));
        xv  = int'($floor(real'(amp) * $cos(th) + 0.5));
        yv  = int'($floor(real'(amp) * $sin(th) + 0.5));
        run_conv(xv, yv, ang, cyc);
        check_near("sweep_rot", xv, yv, ang, 32);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
